// File: rtl/dcache_axi_bridge.sv
// AXI master for dcache misses: 8-beat line fill or writeback and single-beat uncached access.
// One request at a time; s2 sees a rend/wend pulse plus the 256-bit fill line.
module dcache_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ca_rreq_i,
  input  logic         ca_wreq_i,
  input  logic         uc_rreq_i,
  input  logic         uc_wreq_i,
  input  logic [31:0]  addr_i,
  input  logic [3:0]   wen_i,
  input  logic [31:0]  uc_wdata_i,
  input  logic [255:0] wline_i,
  output logic         rend_o,
  output logic         wend_o,
  output logic [255:0] cacheline_rdata_o,
  output logic [3:0]   arid_o,
  output logic [31:0]  araddr_o,
  output logic [7:0]   arlen_o,
  output logic [2:0]   arsize_o,
  output logic [1:0]   arburst_o,
  output logic         arvalid_o,
  input  logic         arready_i,
  input  logic [31:0]  rdata_i,
  input  logic         rlast_i,
  input  logic         rvalid_i,
  output logic         rready_o,
  output logic [3:0]   awid_o,
  output logic [31:0]  awaddr_o,
  output logic [7:0]   awlen_o,
  output logic [2:0]   awsize_o,
  output logic [1:0]   awburst_o,
  output logic         awvalid_o,
  input  logic         awready_i,
  output logic [31:0]  wdata_o,
  output logic [3:0]   wstrb_o,
  output logic         wlast_o,
  output logic         wvalid_o,
  input  logic         wready_i,
  input  logic         bvalid_i,
  output logic         bready_o
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        is_uc_q, is_wr_q;
  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] uc_wdata_q;
  logic [2:0]  cnt_q;
  logic [31:0] wline_q [8];
  logic [31:0] line_q  [8];

  logic       any_req, accept, acc_uc, acc_wr;
  logic       r_beat, w_beat;
  logic [2:0] len;

  // Priority uc_r > uc_w > ca_r > ca_w falls out of the acc_wr decode.
  assign any_req = uc_rreq_i | uc_wreq_i | ca_rreq_i | ca_wreq_i;
  assign accept  = (state_q == S_IDLE) && any_req;
  assign acc_uc  = uc_rreq_i | uc_wreq_i;
  assign acc_wr  = !uc_rreq_i && (uc_wreq_i || !ca_rreq_i);

  assign len    = is_uc_q ? 3'd0 : 3'd7;
  assign r_beat = (state_q == S_R) && rvalid_i;
  assign w_beat = (state_q == S_W) && wready_i;

  assign arid_o    = AXI_ID;
  assign araddr_o  = addr_q;
  assign arlen_o   = {5'd0, len};
  assign arsize_o  = 3'd2;
  assign arburst_o = 2'b01;
  assign awid_o    = AXI_ID;
  assign awaddr_o  = addr_q;
  assign awlen_o   = {5'd0, len};
  assign awsize_o  = 3'd2;
  assign awburst_o = 2'b01;
  assign wdata_o   = is_uc_q ? uc_wdata_q : wline_q[cnt_q];
  assign wstrb_o   = is_uc_q ? wen_q : 4'hF;
  assign wlast_o   = (cnt_q == len);

  always_comb begin
    state_d   = state_q;
    arvalid_o = 1'b0;
    rready_o  = 1'b0;
    awvalid_o = 1'b0;
    wvalid_o  = 1'b0;
    bready_o  = 1'b0;
    rend_o    = 1'b0;
    wend_o    = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = acc_wr ? S_AW : S_AR;
      S_AR: begin
        arvalid_o = 1'b1;
        if (arready_i) state_d = S_R;
      end
      S_R: begin
        rready_o = 1'b1;
        if (rvalid_i && rlast_i) state_d = S_DONE;
      end
      S_AW: begin
        awvalid_o = 1'b1;
        if (awready_i) state_d = S_W;
      end
      S_W: begin
        wvalid_o = 1'b1;
        if (wready_i && wlast_o) state_d = S_B;
      end
      S_B: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = S_DONE;
      end
      // DONE always returns to IDLE so a still-held level request is not re-taken here.
      S_DONE: begin
        rend_o  = !is_wr_q;
        wend_o  = is_wr_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_uc_q    <= 1'b0;
      is_wr_q    <= 1'b0;
      addr_q     <= 32'd0;
      wen_q      <= 4'd0;
      uc_wdata_q <= 32'd0;
      cnt_q      <= 3'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_uc_q <= acc_uc;
        is_wr_q <= acc_wr;
        addr_q  <= acc_uc ? addr_i : {addr_i[31:5], 5'b0};
        cnt_q   <= 3'd0;
        if (acc_wr) begin
          wen_q      <= wen_i;
          uc_wdata_q <= uc_wdata_i;
        end
      end else if (r_beat || w_beat) begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

  // Uncached reads broadcast the beat to every word so any addr[4:2] select sees it.
  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wline_q[gi] <= 32'd0;
        line_q[gi]  <= 32'd0;
      end else begin
        if (accept && acc_wr) wline_q[gi] <= wline_i[32*gi +: 32];
        if (r_beat && (is_uc_q || cnt_q == 3'(gi))) line_q[gi] <= rdata_i;
      end
    end
    assign cacheline_rdata_o[32*gi +: 32] = line_q[gi];
  end

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed plus randomized bench for dcache_axi_bridge with a transaction-level reference model.
module tb_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         ca_rreq_i, ca_wreq_i, uc_rreq_i, uc_wreq_i;
  logic [31:0]  addr_i;
  logic [3:0]   wen_i;
  logic [31:0]  uc_wdata_i;
  logic [255:0] wline_i;
  logic         rend_o, wend_o;
  logic [255:0] cacheline_rdata_o;
  logic [3:0]   arid_o, awid_o;
  logic [31:0]  araddr_o, awaddr_o;
  logic [7:0]   arlen_o, awlen_o;
  logic [2:0]   arsize_o, awsize_o;
  logic [1:0]   arburst_o, awburst_o;
  logic         arvalid_o, arready_i;
  logic [31:0]  rdata_i;
  logic         rlast_i, rvalid_i, rready_o;
  logic         awvalid_o, awready_i;
  logic [31:0]  wdata_o;
  logic [3:0]   wstrb_o;
  logic         wlast_o, wvalid_o, wready_i;
  logic         bvalid_i, bready_o;

  dcache_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .ca_rreq_i(ca_rreq_i), .ca_wreq_i(ca_wreq_i), .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i),
    .addr_i(addr_i), .wen_i(wen_i), .uc_wdata_i(uc_wdata_i), .wline_i(wline_i),
    .rend_o(rend_o), .wend_o(wend_o), .cacheline_rdata_o(cacheline_rdata_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_line [8];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {uc_rreq_i, uc_wreq_i, ca_rreq_i, ca_wreq_i} = 4'b0;
    addr_i = 32'd0; wen_i = 4'd0; uc_wdata_i = 32'd0; wline_i = '0;
    arready_i = 1'b0; rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = 32'd0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
  endtask

  function automatic logic [255:0] pack_line();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = exp_line[k];
    return v;
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, arvalid_o, 0);
    chk({tag, "_awvalid"}, awvalid_o, 0);
    chk({tag, "_wvalid"},  wvalid_o, 0);
    chk({tag, "_rready"},  rready_o, 0);
    chk({tag, "_bready"},  bready_o, 0);
    chk({tag, "_rend"},    rend_o, 0);
    chk({tag, "_wend"},    wend_o, 0);
  endtask

  // reqs = {uc_r, uc_w, ca_r, ca_w}; called in an IDLE cycle, returns in the cycle after DONE.
  task automatic run_txn(input logic [3:0] reqs, input logic [31:0] addr, input logic [255:0] line,
                         input logic [31:0] ucd, input logic [3:0] wen, input bit zw, input bit hold);
    bit          is_uc, is_wr;
    int          beats, t0, lat, d;
    logic [31:0] exp_addr, word;
    if (reqs[3])      begin is_uc = 1; is_wr = 0; end
    else if (reqs[2]) begin is_uc = 1; is_wr = 1; end
    else if (reqs[1]) begin is_uc = 0; is_wr = 0; end
    else              begin is_uc = 0; is_wr = 1; end
    beats    = is_uc ? 1 : 8;
    exp_addr = is_uc ? addr : (addr & 32'hFFFF_FFE0);
    {uc_rreq_i, uc_wreq_i, ca_rreq_i, ca_wreq_i} = reqs;
    addr_i = addr; wline_i = line; uc_wdata_i = ucd; wen_i = wen;
    t0  = cyc;
    lat = 2;
    tick();
    if (!hold) {uc_rreq_i, uc_wreq_i, ca_rreq_i, ca_wreq_i} = 4'b0;
    addr_i = $urandom; wline_i = {8{$urandom}}; uc_wdata_i = $urandom; wen_i = 4'($urandom);
    if (!is_wr) begin
      chk("arvalid", arvalid_o, 1);
      chk("araddr", araddr_o, exp_addr);
      chk("arlen", arlen_o, beats - 1);
      chk("arsize", arsize_o, 2);
      chk("arburst", arburst_o, 1);
      chk("arid", arid_o, 1);
      chk("awvalid_on_read", awvalid_o, 0);
      d = zw ? 0 : int'($urandom_range(1, 3));
      lat += d;
      repeat (d) begin
        tick();
        chk("arvalid_hold", arvalid_o, 1);
        chk("araddr_hold", araddr_o, exp_addr);
      end
      arready_i = 1'b1; tick(); arready_i = 1'b0;
      for (int k = 0; k < beats; k++) begin
        d = zw ? 0 : int'($urandom_range(0, 2));
        lat += d + 1;
        repeat (d) begin
          chk("rready_gap", rready_o, 1);
          tick();
        end
        chk("rready", rready_o, 1);
        word = is_uc ? ucd : line[32*k +: 32];
        rvalid_i = 1'b1; rdata_i = word; rlast_i = (k == beats - 1);
        tick();
        rvalid_i = 1'b0; rlast_i = 1'b0; rdata_i = $urandom;
        if (is_uc) for (int j = 0; j < 8; j++) exp_line[j] = word;
        else exp_line[k] = word;
      end
      chk("rend", rend_o, 1);
      chk("wend_on_read", wend_o, 0);
    end else begin
      chk("awvalid", awvalid_o, 1);
      chk("awaddr", awaddr_o, exp_addr);
      chk("awlen", awlen_o, beats - 1);
      chk("awburst", awburst_o, 1);
      chk("awid", awid_o, 1);
      chk("wvalid_before_aw", wvalid_o, 0);
      chk("arvalid_on_write", arvalid_o, 0);
      d = zw ? 0 : int'($urandom_range(1, 3));
      lat += d;
      repeat (d) begin
        tick();
        chk("awvalid_hold", awvalid_o, 1);
        chk("awaddr_hold", awaddr_o, exp_addr);
        chk("wvalid_before_aw", wvalid_o, 0);
      end
      awready_i = 1'b1; tick(); awready_i = 1'b0;
      for (int k = 0; k < beats; k++) begin
        word = is_uc ? ucd : line[32*k +: 32];
        d = zw ? 0 : int'($urandom_range(0, 1));
        lat += d + 1;
        repeat (d) begin
          chk("wvalid_hold", wvalid_o, 1);
          chk("wdata_hold", wdata_o, word);
          tick();
        end
        chk("wvalid", wvalid_o, 1);
        chk("wdata", wdata_o, word);
        chk("wstrb", wstrb_o, is_uc ? wen : 4'hF);
        chk("wlast", wlast_o, k == beats - 1);
        wready_i = 1'b1; tick(); wready_i = 1'b0;
      end
      chk("bready", bready_o, 1);
      chk("wvalid_after_last", wvalid_o, 0);
      d = zw ? 0 : int'($urandom_range(0, 3));
      lat += d + 1;
      repeat (d) begin
        tick();
        chk("bready_hold", bready_o, 1);
      end
      bvalid_i = 1'b1; tick(); bvalid_i = 1'b0;
      chk("wend", wend_o, 1);
      chk("rend_on_write", rend_o, 0);
    end
    chk("latency", cyc - t0, lat);
    chk("line", cacheline_rdata_o, pack_line());
    $display("txn reqs=%b uc=%0d wr=%0d addr=%h latency=%0d", reqs, is_uc, is_wr, exp_addr, lat);
    tick();
    chk_quiet("after_done");
  endtask

  initial begin
    logic [3:0] r;
    rst = 1'b0;
    idle_inputs();
    for (int k = 0; k < 8; k++) exp_line[k] = 32'd0;
    #2 rst = 1'b1;
    #2;
    chk_quiet("reset");
    chk("reset_line", cacheline_rdata_o, 256'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk_quiet("post_reset");

    // Clean fill, zero-wait
    run_txn(4'b0010, 32'h1000_0044, mk_line(32'hA0), 32'd0, 4'd0, 1, 0);
    // Writeback then fill on the very next cycle
    run_txn(4'b0001, 32'h2000_0020, mk_line(32'hB0), 32'd0, 4'd0, 0, 0);
    run_txn(4'b0010, 32'h2000_0020, mk_line(32'hC0), 32'd0, 4'd0, 0, 0);
    // Uncached read and write
    run_txn(4'b1000, 32'hBFAF_8004, '0, 32'h1234_5678, 4'd0, 1, 0);
    run_txn(4'b0100, 32'hBFAF_8008, '0, 32'hDEAD_BEEF, 4'b0011, 0, 0);
    run_txn(4'b0100, 32'hBFAF_800C, '0, 32'h0BAD_F00D, 4'b1100, 1, 0);
    // Priority with request held through DONE
    run_txn(4'b1010, 32'hBFC0_0010, mk_line(32'hD0), 32'h5555_AAAA, 4'd0, 1, 1);
    run_txn(4'b1010, 32'hBFC0_0014, mk_line(32'hD0), 32'h6666_9999, 4'd0, 0, 0);
    run_txn(4'b0111, 32'h3000_0060, mk_line(32'hE0), 32'h7777_1111, 4'b0101, 0, 0);
    run_txn(4'b0011, 32'h3000_0080, mk_line(32'hF0), 32'd0, 4'd0, 1, 0);

    // Reset during beat 4 of a fill
    ca_rreq_i = 1'b1; addr_i = 32'h4000_0100;
    tick();
    ca_rreq_i = 1'b0;
    arready_i = 1'b1; tick(); arready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rvalid_i = 1'b1; rdata_i = $urandom; tick();
    end
    rvalid_i = 1'b1; rdata_i = $urandom;
    #1 rst = 1'b1;
    #1;
    chk_quiet("mid_reset");
    rvalid_i = 1'b0;
    for (int k = 0; k < 8; k++) exp_line[k] = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_reset_line", cacheline_rdata_o, 256'd0);
    tick();
    chk_quiet("after_mid_reset");
    $display("txn reset during fill beat 4");
    run_txn(4'b0010, 32'h4000_0100, mk_line(32'h100), 32'd0, 4'd0, 1, 0);

    for (int n = 0; n < 24; n++) begin
      r = 4'($urandom_range(1, 15));
      run_txn(r, $urandom, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              $urandom, 4'($urandom), bit'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
# dcache_axi_bridge

Data-cache AXI master sitting directly downstream of the dcache second stage. It accepts one miss/writeback/uncached request at a time from s2 and runs the matching AXI transaction:
- 8-beat INCR line fill
- 8-beat line writeback
- single-beat uncached read or write

It returns completion pulses (`rend_o`, `wend_o`) and the 256-bit fill line back to s2.

## Interface
Parameters:
- `AXI_ID`, 4'd1 — fixed ARID/AWID value.

Ports:
- `clk` in 1 — clock; all state changes on the rising edge.
- `rst` in 1 — reset; one clock, reset is asynchronous and active-high.
- `ca_rreq_i` in 1 — cached line-fill request (level).
- `ca_wreq_i` in 1 — cached line-writeback request (level).
- `uc_rreq_i` in 1 — uncached word read request (level).
- `uc_wreq_i` in 1 — uncached word write request (level).
- `addr_i` in 32 — request address; line-aligned for ca requests.
- `wen_i` in 4 — byte enables for uncached write.
- `uc_wdata_i` in 32 — uncached write data.
- `wline_i` in 256 — victim line for writeback; word k at [32k+31:32k].
- `rend_o` out 1 — read complete, one-cycle pulse.
- `wend_o` out 1 — write complete, one-cycle pulse.
- `cacheline_rdata_o` out 256 — fill line; word k at [32k+31:32k].
- AXI AR channel: `arid_o` 4, `araddr_o` 32, `arlen_o` 8, `arsize_o` 3, `arburst_o` 2, `arvalid_o` 1 out; `arready_i` 1 in.
- AXI R channel: `rdata_i` 32, `rlast_i` 1, `rvalid_i` 1 in; `rready_o` 1 out.
- AXI AW channel: `awid_o` 4, `awaddr_o` 32, `awlen_o` 8, `awsize_o` 3, `awburst_o` 2, `awvalid_o` 1 out; `awready_i` 1 in.
- AXI W channel: `wdata_o` 32, `wstrb_o` 4, `wlast_o` 1, `wvalid_o` 1 out; `wready_i` 1 in.
- AXI B channel: `bvalid_i` 1 in; `bready_o` 1 out.

## Operation
- **States**
  - IDLE
  - AR, R (read path)
  - AW, W, B (write path)
  - DONE
- **Acceptance**
  - Requests are sampled only in IDLE.
  - Priority when several are high: uc_r > uc_w > ca_r > ca_w.
- **Latching at acceptance**
  - Latch `addr_i`, kind, and transaction parameters.
  - Write kinds also latch `wen_i`, `uc_wdata_i` and `wline_i`.
  - Inputs are ignored after acceptance.
- **Transaction parameters by kind**
  - ca read: `araddr`={addr[31:5],5'b0}, `arlen`=7, `arsize`=2, `arburst`=INCR.
  - uc read: `araddr`=addr, `arlen`=0, `arsize`=2.
  - ca write: `awaddr`={addr[31:5],5'b0}, `awlen`=7, all 8 `wstrb`=4'hF.
  - uc write: `awaddr`=addr, `awlen`=0, `wstrb`=latched `wen`.
- **Read path**
  - AR: hold `arvalid` until `arready`, then go to R.
  - R: `rready`=1; a 3-bit beat counter stores each accepted beat into word[cnt] and increments.
  - On the beat with `rlast` go to DONE.
  - An uncached read writes its single beat into all 8 words, so s2's addr[4:2] select returns it.
- **Write path**
  - AW: hold `awvalid` until `awready`, then go to W.
  - W: `wdata`=word[cnt] of the latched line (or `uc_wdata`); `wlast`=(cnt==awlen).
  - Beat advances on `wvalid&&wready`. After the last beat go to B.
  - B: `bready`=1; on `bvalid` go to DONE.
- **DONE**
  - Lasts exactly one cycle: `rend_o`=1 for reads, `wend_o`=1 for writes. Then IDLE.
  - Requests seen in DONE are not accepted; this prevents re-accepting s2's still-asserted level request.
- `rresp`/`bresp` are ignored; no error reporting.
- `cacheline_rdata_o` holds the last filled line until the next read beat overwrites it.
- Constant outputs: ID=`AXI_ID`, `arburst`=`awburst`=2'b01.

## Timing
- **Reset**
  - State IDLE; all valid/ready outputs 0.
  - `rend_o`=`wend_o`=0; counter 0; `cacheline_rdata_o`=0.
  - Reset mid-transaction drops all valids immediately and abandons the transaction.
- **Read timing**
  - Accept at cycle T; `arvalid` high from T+1.
  - With zero-wait slave: AR handshake T+1, beats T+2..T+9, `rend` at T+10.
  - Uncached read: `rend` at T+3.
- **Write timing**
  - Zero-wait: AW T+1, W beats T+2..T+9, B T+10, `wend` T+11.
  - Uncached write: `wend` at T+4.
- **Handshake rules**
  - `arvalid`/`awvalid`/`wvalid` never deassert before their ready handshake.
  - Payload is stable while valid is high.
  - W is not issued before the AW handshake completes.
- **Back-to-back**
  - Dirty miss: `wend` at cycle X, IDLE at X+1.
  - s2's `ca_rreq` at X+1 is accepted that cycle; `arvalid` at X+2.
- A data beat arriving in the same cycle as its address handshake is impossible by protocol; no special case.

## Test plan
- **Clean fill:** `ca_rreq`, addr 0x1000_0044, zero-wait slave returning 0xA0..0xA7 → `araddr`=0x1000_0040, `arlen`=7; `rend` one cycle at T+10; line word k=0xA0+k.
- **Writeback then fill:** `ca_wreq` addr 0x2000_0020, line words 0xB0..0xB7; `awready` delayed 3 cycles, `wready` toggling → 8 beats in order, `wlast` only on 0xB7, `wend` once. `ca_rreq` next cycle accepted, `arvalid` one cycle later.
- **Uncached read:** addr 0xBFAF_8004, `rdata`=0x1234_5678 → `arlen`=0, `rend` at T+3, all 8 words=0x1234_5678.
- **Uncached write:** `wen`=4'b0011, data 0xDEAD_BEEF → `awlen`=0, `wstrb`=0011, `wlast`=1, `wend` after `bvalid`.
- **Priority and DONE guard:** `uc_rreq` and `ca_rreq` both high in IDLE → uncached read taken first. Request held high through DONE → not re-accepted in DONE; accepted the following IDLE cycle.
- **Reset:** assert `rst` during beat 4 of a fill → all valids 0 immediately; IDLE; no `rend`. Next request runs normally.
